stk_cmd_init: RTL and testbench

Per-engine command initiator that drives one lane of the stack pipeline's command interface (`cmd_opcode`/`cmd_dat` in, `cmd_ack`/`rsp_vld` out). It buffers client requests in a small FIFO and presents each as a level-held command until acknowledged. It then waits for the pipeline's completion pulse, with a timeout, and returns a completion to the client over a valid/ready handshake. One instance sits beside each engine lane `[e]` of the stack pipe; exactly one command per engine is outstanding at a time.

---
 rtl/stk_cmd_init.sv | 156 +++++++++++++++
 tb/tb_stk_cmd_init.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stk_cmd_init.sv
// Per-engine command initiator: queues client requests, drives one stack-pipe command lane,
// waits for the completion pulse (with timeout) and hands a completion back to the client.

package stk_pkg;
    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_PEEK = 2'd3
    } opcode_t;
endpackage

module stk_cmd_init #(
    parameter int DEPTH   = 4,
    parameter int DAT_W   = 128,
    parameter int TMO_CYC = 64
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 i_req_vld,
    input  stk_pkg::opcode_t     i_req_opcode,
    input  logic [DAT_W-1:0]     i_req_dat,
    output logic                 o_req_rdy,
    output stk_pkg::opcode_t     o_cmd_opcode,
    output logic [DAT_W-1:0]     o_cmd_dat,
    input  logic                 i_cmd_ack,
    input  logic                 i_rsp_vld,
    output logic                 o_rsp_vld,
    output stk_pkg::opcode_t     o_rsp_opcode,
    output logic                 o_rsp_tmo,
    input  logic                 i_rsp_rdy,
    output logic                 o_err_spurious,
    output logic                 o_busy
);
    import stk_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TMO_CYC);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    opcode_t          op_mem  [DEPTH];
    logic [DAT_W-1:0] dat_mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             rdy_q;
    logic [1:0]       state_q, state_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    opcode_t          rsp_op_q, rsp_op_d;
    logic             rsp_tmo_q, rsp_tmo_d;
    logic             err_q;
    logic             push, pop;
    opcode_t          head_op;
    logic [DAT_W-1:0] head_dat;

    // Ready comes from the registered count, so a full FIFO refuses even when popping.
    assign push     = i_req_vld & rdy_q;
    assign head_op  = op_mem[rd_ptr_q];
    assign head_dat = dat_mem[rd_ptr_q];
    assign count_d  = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q]  <= i_req_opcode;
            dat_mem[wr_ptr_q] <= i_req_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            rdy_q   <= (count_d != FULL_CNT);
        end
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        tmo_cnt_d = tmo_cnt_q;
        rsp_op_d  = rsp_op_q;
        rsp_tmo_d = rsp_tmo_q;
        case (state_q)
            ST_IDLE: begin
                // NOP entries are dropped here and never reach the pipe.
                if (count_q != '0) begin
                    if (head_op == OP_NOP) pop = 1'b1;
                    else                   state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_cmd_ack) begin
                    pop       = 1'b1;
                    rsp_op_d  = head_op;
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_rsp_vld) begin
                    rsp_tmo_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_tmo_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            ST_RESP: begin
                if (i_rsp_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= '0;
            rsp_op_q  <= OP_NOP;
            rsp_tmo_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            rsp_op_q  <= rsp_op_d;
            rsp_tmo_q <= rsp_tmo_d;
            // Any completion pulse outside WAIT, including one arriving after a timeout.
            if (i_rsp_vld && state_q != ST_WAIT) err_q <= 1'b1;
        end
    end

    assign o_req_rdy      = rdy_q;
    assign o_cmd_opcode   = (state_q == ST_ISSUE) ? head_op : OP_NOP;
    assign o_cmd_dat      = (state_q == ST_ISSUE) ? head_dat : '0;
    assign o_rsp_vld      = (state_q == ST_RESP);
    assign o_rsp_opcode   = rsp_op_q;
    assign o_rsp_tmo      = rsp_tmo_q;
    assign o_err_spurious = err_q;
    assign o_busy         = (state_q != ST_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_stk_cmd_init.sv
// Directed bench for stk_cmd_init: reset, single command, FIFO full/wrap, timeout,
// simultaneous response/timeout with back-pressure, and reset mid-operation.

module tb_stk_cmd_init;
    import stk_pkg::*;

    localparam int DEPTH   = 4;
    localparam int DAT_W   = 128;
    localparam int TMO_CYC = 64;

    logic             clk = 1'b0;
    logic             srst;
    logic             i_req_vld;
    opcode_t          i_req_opcode;
    logic [DAT_W-1:0] i_req_dat;
    logic             o_req_rdy;
    opcode_t          o_cmd_opcode;
    logic [DAT_W-1:0] o_cmd_dat;
    logic             i_cmd_ack;
    logic             i_rsp_vld;
    logic             o_rsp_vld;
    opcode_t          o_rsp_opcode;
    logic             o_rsp_tmo;
    logic             i_rsp_rdy;
    logic             o_err_spurious;
    logic             o_busy;

    int vec  = 0;
    int miss = 0;

    stk_cmd_init #(.DEPTH(DEPTH), .DAT_W(DAT_W), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .srst(srst),
        .i_req_vld(i_req_vld), .i_req_opcode(i_req_opcode), .i_req_dat(i_req_dat),
        .o_req_rdy(o_req_rdy),
        .o_cmd_opcode(o_cmd_opcode), .o_cmd_dat(o_cmd_dat), .i_cmd_ack(i_cmd_ack),
        .i_rsp_vld(i_rsp_vld),
        .o_rsp_vld(o_rsp_vld), .o_rsp_opcode(o_rsp_opcode), .o_rsp_tmo(o_rsp_tmo),
        .i_rsp_rdy(i_rsp_rdy),
        .o_err_spurious(o_err_spurious), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_issue(output bit found);
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (o_cmd_opcode != OP_NOP) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic service(output opcode_t cop, output logic [DAT_W-1:0] cdat,
                           output opcode_t rop, output logic rv, output bit found);
        wait_issue(found);
        cop  = o_cmd_opcode;
        cdat = o_cmd_dat;
        i_cmd_ack = 1'b1; step(); i_cmd_ack = 1'b0;
        step();
        i_rsp_vld = 1'b1; step(); i_rsp_vld = 1'b0;
        rv  = o_rsp_vld;
        rop = o_rsp_opcode;
        i_rsp_rdy = 1'b1; step(); i_rsp_rdy = 1'b0;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        step();
        vec++; if (o_req_rdy !== 1'b0) begin miss++; $display("FAIL reset_rdy_low: got %b want 0", o_req_rdy); end
        step();
        srst = 1'b0;
        step();
        vec++;
        if (o_req_rdy !== 1'b1 || o_cmd_opcode !== OP_NOP || o_cmd_dat !== '0 || o_rsp_vld !== 1'b0 ||
            o_rsp_opcode !== OP_NOP || o_rsp_tmo !== 1'b0 || o_err_spurious !== 1'b0 || o_busy !== 1'b0) begin
            miss++;
            $display("FAIL reset_outputs: rdy=%b cmd=%0d dat=%h rv=%b rop=%0d tmo=%b err=%b busy=%b want 1 0 0 0 0 0 0 0",
                     o_req_rdy, o_cmd_opcode, o_cmd_dat, o_rsp_vld, o_rsp_opcode, o_rsp_tmo, o_err_spurious, o_busy);
        end
        $display("reset: rdy=%b busy=%b", o_req_rdy, o_busy);
    endtask

    task automatic test_single_push();
        // cycle 0
        i_req_vld = 1'b1; i_req_opcode = OP_PUSH; i_req_dat = 128'hDEAD;
        step(); i_req_vld = 1'b0;                                   // cycle 1
        vec++; if (o_cmd_opcode !== OP_NOP) begin miss++; $display("FAIL single_c1_nop: got %0d want 0", o_cmd_opcode); end
        step();                                                     // cycle 2
        vec++; if (o_cmd_opcode !== OP_PUSH || o_cmd_dat !== 128'hDEAD) begin
            miss++; $display("FAIL single_c2_cmd: got op=%0d dat=%h want 1 dead", o_cmd_opcode, o_cmd_dat); end
        step();                                                     // cycle 3
        vec++; if (o_cmd_opcode !== OP_PUSH || o_cmd_dat !== 128'hDEAD) begin
            miss++; $display("FAIL single_c3_cmd: got op=%0d dat=%h want 1 dead", o_cmd_opcode, o_cmd_dat); end
        i_cmd_ack = 1'b1;
        step(); i_cmd_ack = 1'b0;                                   // cycle 4
        vec++; if (o_cmd_opcode !== OP_NOP || o_cmd_dat !== '0 || o_busy !== 1'b1) begin
            miss++; $display("FAIL single_c4_wait: got op=%0d dat=%h busy=%b want 0 0 1", o_cmd_opcode, o_cmd_dat, o_busy); end
        step(); step();                                             // cycle 6
        vec++; if (o_rsp_vld !== 1'b0) begin miss++; $display("FAIL single_c6_norsp: got %b want 0", o_rsp_vld); end
        i_rsp_vld = 1'b1;
        step(); i_rsp_vld = 1'b0;                                   // cycle 7
        vec++; if (o_rsp_vld !== 1'b1 || o_rsp_opcode !== OP_PUSH || o_rsp_tmo !== 1'b0) begin
            miss++; $display("FAIL single_c7_rsp: got vld=%b op=%0d tmo=%b want 1 1 0", o_rsp_vld, o_rsp_opcode, o_rsp_tmo); end
        i_rsp_rdy = 1'b1;
        step(); i_rsp_rdy = 1'b0;                                   // cycle 8
        vec++; if (o_rsp_vld !== 1'b0 || o_busy !== 1'b0 || o_err_spurious !== 1'b0) begin
            miss++; $display("FAIL single_c8_done: got vld=%b busy=%b err=%b want 0 0 0", o_rsp_vld, o_busy, o_err_spurious); end
        $display("single_push: rsp_op=%0d", o_rsp_opcode);
    endtask

    task automatic test_fifo_full_wrap();
        opcode_t          ops1 [6];
        opcode_t          ops2 [4];
        int               idx2 [3];
        opcode_t          cop, rop;
        logic [DAT_W-1:0] cdat, edat;
        logic             rv;
        bit               found;
        ops1 = '{OP_PUSH, OP_POP, OP_PEEK, OP_PUSH, OP_POP, OP_PUSH};
        ops2 = '{OP_PUSH, OP_NOP, OP_POP, OP_PUSH};
        idx2 = '{0, 2, 3};
        for (int i = 0; i < 6; i++) begin
            i_req_vld = 1'b1; i_req_opcode = ops1[i]; i_req_dat = DAT_W'(32'h100 + i);
            vec++; if (o_req_rdy !== (i < 4)) begin
                miss++; $display("FAIL full_rdy[%0d]: got %b want %b", i, o_req_rdy, (i < 4)); end
            step();
        end
        i_req_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            service(cop, cdat, rop, rv, found);
            edat = DAT_W'(32'h100 + i);
            vec++; if (!found || cop !== ops1[i] || cdat !== edat) begin
                miss++; $display("FAIL full_issue[%0d]: got found=%b op=%0d dat=%h want 1 %0d %h", i, found, cop, cdat, ops1[i], edat); end
            vec++; if (rv !== 1'b1 || rop !== ops1[i]) begin
                miss++; $display("FAIL full_rsp[%0d]: got vld=%b op=%0d want 1 %0d", i, rv, rop, ops1[i]); end
            $display("full_wrap batch1[%0d]: op=%0d dat=%h", i, cop, cdat);
        end
        for (int i = 0; i < 4; i++) begin
            i_req_vld = 1'b1; i_req_opcode = ops2[i]; i_req_dat = DAT_W'(32'h200 + i);
            vec++; if (o_req_rdy !== 1'b1) begin miss++; $display("FAIL wrap_rdy[%0d]: got %b want 1", i, o_req_rdy); end
            step();
        end
        i_req_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            service(cop, cdat, rop, rv, found);
            edat = DAT_W'(32'h200 + idx2[k]);
            vec++; if (!found || cop !== ops2[idx2[k]] || cdat !== edat || rv !== 1'b1) begin
                miss++; $display("FAIL wrap_issue[%0d]: got found=%b op=%0d dat=%h vld=%b want 1 %0d %h 1",
                                 k, found, cop, cdat, rv, ops2[idx2[k]], edat); end
            $display("full_wrap batch2[%0d]: op=%0d dat=%h", k, cop, cdat);
        end
        step();
        vec++; if (o_busy !== 1'b0 || o_cmd_opcode !== OP_NOP) begin
            miss++; $display("FAIL wrap_drained: got busy=%b cmd=%0d want 0 0", o_busy, o_cmd_opcode); end
    endtask

    task automatic test_timeout();
        bit found;
        int n;
        i_req_vld = 1'b1; i_req_opcode = OP_PEEK; i_req_dat = 128'h55;
        step(); i_req_vld = 1'b0;
        wait_issue(found);
        vec++; if (!found) begin miss++; $display("FAIL tmo_issue: got no issue want issue"); end
        i_cmd_ack = 1'b1;
        step(); i_cmd_ack = 1'b0;
        n = 1;
        while (!o_rsp_vld && n < 200) begin
            step();
            n++;
        end
        vec++; if (n != TMO_CYC + 1) begin miss++; $display("FAIL tmo_latency: got %0d want %0d", n, TMO_CYC + 1); end
        vec++; if (o_rsp_vld !== 1'b1 || o_rsp_tmo !== 1'b1 || o_rsp_opcode !== OP_PEEK) begin
            miss++; $display("FAIL tmo_rsp: got vld=%b tmo=%b op=%0d want 1 1 3", o_rsp_vld, o_rsp_tmo, o_rsp_opcode); end
        vec++; if (o_err_spurious !== 1'b0) begin miss++; $display("FAIL tmo_err_pre: got %b want 0", o_err_spurious); end
        i_rsp_rdy = 1'b1; step(); i_rsp_rdy = 1'b0;
        i_rsp_vld = 1'b1; step(); i_rsp_vld = 1'b0;
        step();
        vec++; if (o_err_spurious !== 1'b1) begin miss++; $display("FAIL tmo_err_late: got %b want 1", o_err_spurious); end
        $display("timeout: latency=%0d err=%b", n, o_err_spurious);
    endtask

    task automatic test_simultaneous();
        bit found;
        srst = 1'b1; step(); step(); srst = 1'b0; step();
        i_req_vld = 1'b1; i_req_opcode = OP_PUSH; i_req_dat = 128'h1234;
        step(); i_req_vld = 1'b0;
        wait_issue(found);
        vec++; if (!found) begin miss++; $display("FAIL sim_issue: got no issue want issue"); end
        i_cmd_ack = 1'b1;                                           // cycle A
        step(); i_cmd_ack = 1'b0;                                   // A+1
        i_req_vld = 1'b1; i_req_opcode = OP_POP; i_req_dat = 128'h77;
        step(); i_req_vld = 1'b0;                                   // A+2
        repeat (TMO_CYC - 2) step();                                // A+TMO: counter at TMO_CYC-1
        i_rsp_vld = 1'b1;
        step(); i_rsp_vld = 1'b0;
        vec++; if (o_rsp_vld !== 1'b1 || o_rsp_tmo !== 1'b0 || o_rsp_opcode !== OP_PUSH) begin
            miss++; $display("FAIL sim_rsp: got vld=%b tmo=%b op=%0d want 1 0 1", o_rsp_vld, o_rsp_tmo, o_rsp_opcode); end
        for (int i = 0; i < 5; i++) begin
            step();
            vec++; if (o_rsp_vld !== 1'b1 || o_rsp_tmo !== 1'b0 || o_rsp_opcode !== OP_PUSH || o_cmd_opcode !== OP_NOP) begin
                miss++; $display("FAIL sim_hold[%0d]: got vld=%b tmo=%b op=%0d cmd=%0d want 1 0 1 0",
                                 i, o_rsp_vld, o_rsp_tmo, o_rsp_opcode, o_cmd_opcode); end
        end
        i_rsp_rdy = 1'b1; step(); i_rsp_rdy = 1'b0;
        vec++; if (o_rsp_vld !== 1'b0 || o_cmd_opcode !== OP_NOP) begin
            miss++; $display("FAIL sim_bubble: got vld=%b cmd=%0d want 0 0", o_rsp_vld, o_cmd_opcode); end
        step();
        vec++; if (o_cmd_opcode !== OP_POP || o_cmd_dat !== 128'h77) begin
            miss++; $display("FAIL sim_next_issue: got op=%0d dat=%h want 2 77", o_cmd_opcode, o_cmd_dat); end
        i_cmd_ack = 1'b1; step(); i_cmd_ack = 1'b0;
        step();
        i_rsp_vld = 1'b1; step(); i_rsp_vld = 1'b0;
        i_rsp_rdy = 1'b1; step(); i_rsp_rdy = 1'b0;
        vec++; if (o_err_spurious !== 1'b0 || o_busy !== 1'b0) begin
            miss++; $display("FAIL sim_clean: got err=%b busy=%b want 0 0", o_err_spurious, o_busy); end
        $display("simultaneous: tmo=0 path and hold checked");
    endtask

    task automatic test_reset_mid();
        bit found;
        bit bad;
        i_req_vld = 1'b1; i_req_opcode = OP_PUSH; i_req_dat = 128'hA0;
        step(); i_req_vld = 1'b0;
        wait_issue(found);
        i_cmd_ack = 1'b1; step(); i_cmd_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_req_vld = 1'b1; i_req_opcode = OP_POP; i_req_dat = DAT_W'(32'hB0 + i);
            step();
        end
        i_req_vld = 1'b0;
        vec++; if (o_busy !== 1'b1 || !found) begin miss++; $display("FAIL mid_busy_pre: got busy=%b found=%b want 1 1", o_busy, found); end
        srst = 1'b1; step();
        vec++; if (o_req_rdy !== 1'b0) begin miss++; $display("FAIL mid_rdy_in_reset: got %b want 0", o_req_rdy); end
        srst = 1'b0; step();
        vec++; if (o_busy !== 1'b0 || o_req_rdy !== 1'b1 || o_cmd_opcode !== OP_NOP || o_rsp_vld !== 1'b0 || o_rsp_opcode !== OP_NOP) begin
            miss++; $display("FAIL mid_after_reset: got busy=%b rdy=%b cmd=%0d vld=%b rop=%0d want 0 1 0 0 0",
                             o_busy, o_req_rdy, o_cmd_opcode, o_rsp_vld, o_rsp_opcode); end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_rsp_vld !== 1'b0 || o_cmd_opcode !== OP_NOP || o_busy !== 1'b0) bad = 1'b1;
        end
        vec++; if (bad) begin miss++; $display("FAIL mid_quiet: got activity after reset want none"); end
        $display("reset_mid: busy=%b", o_busy);
    endtask

    initial begin
        srst = 1'b1; i_req_vld = 1'b0; i_req_opcode = OP_NOP; i_req_dat = '0;
        i_cmd_ack = 1'b0; i_rsp_vld = 1'b0; i_rsp_rdy = 1'b0;
        test_reset();
        test_single_push();
        test_fifo_full_wrap();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
